axi2core_bridge: RTL and testbench

AXI slave-to-core-protocol bridge: accepts single-beat AXI read and write transactions and re-issues each one as a req/gnt/rvalid transfer on a core-style memory port. It is the responder-side counterpart of the core-to-AXI master adapters on the LSU and instruction ports. It lets peripherals with a native req/gnt/rvalid interface hang directly off an interconnect slave port. One transaction is in flight at a time, and the AXI ID is echoed on the response.

---
 rtl/axi2core_bridge_if.sv | 78 +++++++
 rtl/axi2core_bridge.sv | 144 ++++++++++++++
 tb/tb_axi2core_bridge.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi2core_bridge_if.sv
// Signal bundle between an AXI slave port and a core-style req/gnt/rvalid memory port.
// The bridge takes the slave view; whatever drives AXI and answers the core port takes the master view.
interface axi2core_bridge_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 3
);
   localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

   logic                      aw_valid;
   logic                      aw_ready;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr;
   logic [AXI_ID_WIDTH-1:0]   aw_id;
   logic [7:0]                aw_len;

   logic                      w_valid;
   logic                      w_ready;
   logic [AXI_DATA_WIDTH-1:0] w_data;
   logic [STRB_WIDTH-1:0]     w_strb;
   logic                      w_last;

   logic                      b_valid;
   logic                      b_ready;
   logic [AXI_ID_WIDTH-1:0]   b_id;
   logic [1:0]                b_resp;

   logic                      ar_valid;
   logic                      ar_ready;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr;
   logic [AXI_ID_WIDTH-1:0]   ar_id;
   logic [7:0]                ar_len;

   logic                      r_valid;
   logic                      r_ready;
   logic [AXI_DATA_WIDTH-1:0] r_data;
   logic [AXI_ID_WIDTH-1:0]   r_id;
   logic [1:0]                r_resp;
   logic                      r_last;

   logic                      data_req_o;
   logic                      data_gnt_i;
   logic                      data_rvalid_i;
   logic [AXI_ADDR_WIDTH-1:0] data_addr_o;
   logic                      data_we_o;
   logic [STRB_WIDTH-1:0]     data_be_o;
   logic [AXI_DATA_WIDTH-1:0] data_wdata_o;
   logic [AXI_DATA_WIDTH-1:0] data_rdata_i;

   modport slave (
      input  aw_valid, aw_addr, aw_id, aw_len,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last,
      output w_ready,
      input  b_ready,
      output b_valid, b_id, b_resp,
      input  ar_valid, ar_addr, ar_id, ar_len,
      output ar_ready,
      input  r_ready,
      output r_valid, r_data, r_id, r_resp, r_last,
      output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
      input  data_gnt_i, data_rvalid_i, data_rdata_i
   );

   modport master (
      output aw_valid, aw_addr, aw_id, aw_len,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last,
      input  w_ready,
      output b_ready,
      input  b_valid, b_id, b_resp,
      output ar_valid, ar_addr, ar_id, ar_len,
      input  ar_ready,
      output r_ready,
      input  r_valid, r_data, r_id, r_resp, r_last,
      input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
      output data_gnt_i, data_rvalid_i, data_rdata_i
   );
endinterface

// File: rtl/axi2core_bridge.sv
// Single-beat AXI slave to core req/gnt/rvalid bridge; one transaction in flight,
// AXI ID echoed on the response, bursts rejected with SLVERR without touching the core port.
module axi2core_bridge #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 3
) (
   input logic              clk,
   input logic              rst,
   axi2core_bridge_if.slave bus
);
   localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [3:0] {
      IDLE,
      WR_DATA,
      WR_REQ,
      WR_WAIT,
      WR_RESP,
      WR_DRAIN,
      RD_REQ,
      RD_WAIT,
      RD_RESP
   } state_t;

   state_t                    state_q;
   state_t                    state_d;
   logic                      prio_wr_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [AXI_ID_WIDTH-1:0]   id_q;
   logic                      we_q;
   logic [STRB_WIDTH-1:0]     be_q;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic [AXI_DATA_WIDTH-1:0] rdata_q;
   logic [1:0]                resp_q;

   logic sel_wr;
   logic sel_rd;
   logic aw_hs;
   logic ar_hs;
   logic w_hs;
   logic in_idle;

   // Arbitration: the priority bit breaks the tie only when both address channels are valid.
   always_comb begin
      in_idle = (state_q == IDLE) && !rst;
      sel_wr  = bus.aw_valid && (prio_wr_q || !bus.ar_valid);
      sel_rd  = bus.ar_valid && !sel_wr;
      aw_hs   = in_idle && sel_wr;
      ar_hs   = in_idle && sel_rd;
      w_hs    = bus.w_valid && ((state_q == WR_DATA) || (state_q == WR_DRAIN));
   end

   assign bus.aw_ready     = aw_hs;
   assign bus.ar_ready     = ar_hs;
   assign bus.w_ready      = (state_q == WR_DATA) || (state_q == WR_DRAIN);
   assign bus.b_valid      = (state_q == WR_RESP);
   assign bus.b_id         = id_q;
   assign bus.b_resp       = resp_q;
   assign bus.r_valid      = (state_q == RD_RESP);
   assign bus.r_last       = (state_q == RD_RESP);
   assign bus.r_id         = id_q;
   assign bus.r_resp       = resp_q;
   assign bus.r_data       = rdata_q;
   assign bus.data_req_o   = (state_q == WR_REQ) || (state_q == RD_REQ);
   assign bus.data_addr_o  = addr_q;
   assign bus.data_we_o    = we_q;
   assign bus.data_be_o    = be_q;
   assign bus.data_wdata_o = wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (aw_hs) begin
               state_d = (bus.aw_len == 8'd0) ? WR_DATA : WR_DRAIN;
            end else if (ar_hs) begin
               state_d = (bus.ar_len == 8'd0) ? RD_REQ : RD_RESP;
            end
         end
         WR_DATA:  if (w_hs)               state_d = WR_REQ;
         WR_REQ:   if (bus.data_gnt_i)     state_d = WR_WAIT;
         WR_WAIT:  if (bus.data_rvalid_i)  state_d = WR_RESP;
         WR_RESP:  if (bus.b_ready)        state_d = IDLE;
         WR_DRAIN: if (w_hs && bus.w_last) state_d = WR_RESP;
         RD_REQ:   if (bus.data_gnt_i)     state_d = RD_WAIT;
         RD_WAIT:  if (bus.data_rvalid_i)  state_d = RD_RESP;
         RD_RESP:  if (bus.r_ready)        state_d = IDLE;
         default:                          state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_wr_q <= 1'b1;
      end else if (aw_hs || ar_hs) begin
         prio_wr_q <= !prio_wr_q;
      end
   end

   // Transaction payload; the response code is decided at address acceptance from the burst length.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         id_q    <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         resp_q  <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            addr_q <= bus.aw_addr;
            id_q   <= bus.aw_id;
            we_q   <= 1'b1;
            resp_q <= (bus.aw_len == 8'd0) ? RESP_OKAY : RESP_SLVERR;
         end else if (ar_hs) begin
            addr_q  <= bus.ar_addr;
            id_q    <= bus.ar_id;
            we_q    <= 1'b0;
            be_q    <= '1;
            rdata_q <= '0;
            resp_q  <= (bus.ar_len == 8'd0) ? RESP_OKAY : RESP_SLVERR;
         end
         if (w_hs && (state_q == WR_DATA)) begin
            wdata_q <= bus.w_data;
            be_q    <= bus.w_strb;
         end
         if ((state_q == RD_WAIT) && bus.data_rvalid_i) begin
            rdata_q <= bus.data_rdata_i;
         end
      end
   end
endmodule

// File: tb/tb_axi2core_bridge.sv
// Directed bench for axi2core_bridge: expected responses and core requests are queued by the
// stimulus and popped by an independent monitor whenever the bridge presents a handshake.
module tb_axi2core_bridge;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axi2core_bridge_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) bif ();

   axi2core_bridge #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif)
   );

   typedef struct {
      logic          is_wr;
      logic [IW-1:0] id;
      logic [1:0]    resp;
      logic [DW-1:0] data;
   } rsp_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [3:0]    be;
      logic [DW-1:0] wdata;
   } creq_t;

   rsp_t  rsp_q[$];
   creq_t creq_q[$];
   logic  order_q[$];
   int    checks = 0;
   int    failures = 0;
   int    gnt_delay = 0;
   int    rv_delay = 1;
   int    req_cycles = 0;
   logic [DW-1:0] mem [logic [AW-1:0]];

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [127:0] outs();
      return {10'd0, bif.aw_ready, bif.w_ready, bif.b_valid, bif.ar_ready, bif.r_valid,
              bif.r_last, bif.data_req_o, bif.data_we_o, bif.data_be_o, bif.data_addr_o,
              bif.data_wdata_o, bif.r_data, bif.r_id, bif.b_id, bif.b_resp, bif.r_resp};
   endfunction

   // Core-side responder: grant after gnt_delay cycles of request, complete rv_delay cycles later.
   initial begin : core_model
      int gcnt;
      int rcnt;
      logic [DW-1:0] pdata;
      logic [DW-1:0] cur;
      gcnt = 0;
      rcnt = 0;
      pdata = '0;
      bif.data_gnt_i = 1'b0;
      bif.data_rvalid_i = 1'b0;
      bif.data_rdata_i = '0;
      forever begin
         @(posedge clk);
         #1;
         bif.data_gnt_i = 1'b0;
         bif.data_rvalid_i = 1'b0;
         if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
               bif.data_rvalid_i = 1'b1;
               bif.data_rdata_i = pdata;
            end
         end
         if (bif.data_req_o) begin
            if (gcnt >= gnt_delay) begin
               bif.data_gnt_i = 1'b1;
               gcnt = 0;
               rcnt = rv_delay;
               if (bif.data_we_o) begin
                  cur = mem.exists(bif.data_addr_o) ? mem[bif.data_addr_o] : '0;
                  for (int b = 0; b < 4; b++)
                     if (bif.data_be_o[b]) cur[8*b +: 8] = bif.data_wdata_o[8*b +: 8];
                  mem[bif.data_addr_o] = cur;
                  pdata = '0;
               end else begin
                  pdata = mem.exists(bif.data_addr_o) ? mem[bif.data_addr_o] : 32'h0BAD_F00D;
               end
            end else begin
               gcnt++;
            end
         end else begin
            gcnt = 0;
         end
      end
   end

   initial begin : monitor
      logic p_req;
      logic p_gnt;
      logic p_bv;
      logic p_br;
      logic p_rv;
      logic p_rr;
      logic [127:0] p_core;
      logic [127:0] p_b;
      logic [127:0] p_r;
      rsp_t  e;
      creq_t c;
      p_req = 0; p_gnt = 0; p_bv = 0; p_br = 0; p_rv = 0; p_rr = 0;
      p_core = '0; p_b = '0; p_r = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            p_req = 0;
            p_bv  = 0;
            p_rv  = 0;
         end else begin
            if (bif.aw_ready || bif.ar_ready)
               chk("ready_exclusive", bif.aw_ready && bif.ar_ready, 1'b0);
            if (bif.aw_valid && bif.aw_ready) order_q.push_back(1'b1);
            if (bif.ar_valid && bif.ar_ready) order_q.push_back(1'b0);
            if (bif.data_req_o) req_cycles++;
            if (p_req && !p_gnt)
               chk("core_hold", {bif.data_req_o, bif.data_addr_o, bif.data_we_o, bif.data_be_o, bif.data_wdata_o},
                   {1'b1, p_core[68:0]});
            if (p_bv && !p_br)
               chk("b_hold", {bif.b_valid, bif.b_id, bif.b_resp}, {1'b1, p_b[4:0]});
            if (p_rv && !p_rr)
               chk("r_hold", {bif.r_valid, bif.r_id, bif.r_resp, bif.r_data, bif.r_last}, {1'b1, p_r[37:0]});
            if (bif.data_req_o && bif.data_gnt_i) begin
               if (creq_q.size() == 0) begin
                  chk("core_unexpected", 1'b1, 1'b0);
               end else begin
                  c = creq_q.pop_front();
                  if (c.we)
                     chk("core_wr_req", {bif.data_we_o, bif.data_addr_o, bif.data_be_o, bif.data_wdata_o},
                         {c.we, c.addr, c.be, c.wdata});
                  else
                     chk("core_rd_req", {bif.data_we_o, bif.data_addr_o, bif.data_be_o}, {c.we, c.addr, c.be});
               end
            end
            if (bif.b_valid && bif.b_ready) begin
               if (rsp_q.size() == 0) begin
                  chk("b_unexpected", 1'b1, 1'b0);
               end else begin
                  e = rsp_q.pop_front();
                  chk("b_rsp", {1'b1, bif.b_id, bif.b_resp}, {e.is_wr, e.id, e.resp});
               end
            end
            if (bif.r_valid && bif.r_ready) begin
               if (rsp_q.size() == 0) begin
                  chk("r_unexpected", 1'b1, 1'b0);
               end else begin
                  e = rsp_q.pop_front();
                  chk("r_rsp", {1'b0, bif.r_id, bif.r_resp, bif.r_data, bif.r_last},
                      {e.is_wr, e.id, e.resp, e.data, 1'b1});
               end
            end
            p_req  = bif.data_req_o;
            p_gnt  = bif.data_gnt_i;
            p_core = {59'd0, bif.data_addr_o, bif.data_we_o, bif.data_be_o, bif.data_wdata_o};
            p_bv   = bif.b_valid;
            p_br   = bif.b_ready;
            p_b    = {123'd0, bif.b_id, bif.b_resp};
            p_rv   = bif.r_valid;
            p_rr   = bif.r_ready;
            p_r    = {90'd0, bif.r_id, bif.r_resp, bif.r_data, bif.r_last};
         end
      end
   end

   task automatic axi_write(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                            input logic [DW-1:0] data, input logic [3:0] strb, input int beats,
                            input int bdelay, output int lat);
      int n;
      bif.aw_valid = 1'b1; bif.aw_addr = addr; bif.aw_id = id; bif.aw_len = len;
      n = 0;
      @(negedge clk);
      while (!bif.aw_ready && n < 200) begin n++; @(negedge clk); end
      chk("aw_accept", n < 200, 1'b1);
      @(posedge clk); #1;
      bif.aw_valid = 1'b0;
      for (int i = 0; i < beats; i++) begin
         bif.w_valid = 1'b1; bif.w_data = data + i; bif.w_strb = strb; bif.w_last = (i == beats - 1);
         n = 0;
         @(negedge clk);
         while (!bif.w_ready && n < 200) begin n++; @(negedge clk); end
         chk("w_accept", n < 200, 1'b1);
         @(posedge clk); #1;
      end
      bif.w_valid = 1'b0; bif.w_last = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bif.b_valid && n < 200) begin n++; @(negedge clk); end
      chk("b_arrive", n < 200, 1'b1);
      lat = n + 1;
      repeat (bdelay) @(negedge clk);
      @(posedge clk); #1;
      bif.b_ready = 1'b1;
      @(posedge clk); #1;
      bif.b_ready = 1'b0;
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                           input int rdelay, output int lat);
      int n;
      bif.ar_valid = 1'b1; bif.ar_addr = addr; bif.ar_id = id; bif.ar_len = len;
      n = 0;
      @(negedge clk);
      while (!bif.ar_ready && n < 200) begin n++; @(negedge clk); end
      chk("ar_accept", n < 200, 1'b1);
      @(posedge clk); #1;
      bif.ar_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bif.r_valid && n < 200) begin n++; @(negedge clk); end
      chk("r_arrive", n < 200, 1'b1);
      lat = n;
      repeat (rdelay) @(negedge clk);
      @(posedge clk); #1;
      bif.r_ready = 1'b1;
      @(posedge clk); #1;
      bif.r_ready = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench did not finish");
   end

   initial begin : stim
      int lat;
      int lat2;
      int rc;
      int idx;
      int n;
      logic rv_seen;
      rst = 1'b1;
      bif.aw_valid = 0; bif.aw_addr = '0; bif.aw_id = '0; bif.aw_len = '0;
      bif.w_valid = 0; bif.w_data = '0; bif.w_strb = '0; bif.w_last = 0;
      bif.b_ready = 0;
      bif.ar_valid = 0; bif.ar_addr = '0; bif.ar_id = '0; bif.ar_len = '0;
      bif.r_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", outs(), '0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Write then read back.
      creq_q.push_back('{1'b1, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF});
      rsp_q.push_back('{1'b1, 3'd5, 2'b00, 32'h0});
      axi_write(32'h1000_0010, 3'd5, 8'd0, 32'hDEAD_BEEF, 4'hF, 1, 0, lat);
      chk("write_latency_w_to_b", lat, 3);
      creq_q.push_back('{1'b0, 32'h1000_0010, 4'hF, 32'h0});
      rsp_q.push_back('{1'b0, 3'd2, 2'b00, 32'hDEAD_BEEF});
      axi_read(32'h1000_0010, 3'd2, 8'd0, 0, lat);
      chk("read_latency_ar_to_r", lat, 2);

      // Contention: both channels valid at every arbitration -> W, R, W, R.
      idx = order_q.size();
      creq_q.push_back('{1'b1, 32'h0000_0100, 4'hF, 32'h1111_1111});
      creq_q.push_back('{1'b0, 32'h1000_0010, 4'hF, 32'h0});
      creq_q.push_back('{1'b1, 32'h0000_0104, 4'hF, 32'h2222_2222});
      creq_q.push_back('{1'b0, 32'h0000_0100, 4'hF, 32'h0});
      rsp_q.push_back('{1'b1, 3'd1, 2'b00, 32'h0});
      rsp_q.push_back('{1'b0, 3'd3, 2'b00, 32'hDEAD_BEEF});
      rsp_q.push_back('{1'b1, 3'd4, 2'b00, 32'h0});
      rsp_q.push_back('{1'b0, 3'd6, 2'b00, 32'h1111_1111});
      fork
         begin
            axi_write(32'h0000_0100, 3'd1, 8'd0, 32'h1111_1111, 4'hF, 1, 0, lat);
            axi_write(32'h0000_0104, 3'd4, 8'd0, 32'h2222_2222, 4'hF, 1, 0, lat);
         end
         begin
            axi_read(32'h1000_0010, 3'd3, 8'd0, 0, lat2);
            axi_read(32'h0000_0100, 3'd6, 8'd0, 0, lat2);
         end
      join
      chk("arb_accept_count", order_q.size() - idx, 4);
      if (order_q.size() - idx == 4)
         chk("arb_order", {order_q[idx], order_q[idx+1], order_q[idx+2], order_q[idx+3]}, 4'b1010);

      // Grant held off 5 cycles and b_ready held low; the monitor checks hold stability.
      gnt_delay = 5;
      creq_q.push_back('{1'b1, 32'h0000_0200, 4'hF, 32'hCAFE_F00D});
      rsp_q.push_back('{1'b1, 3'd7, 2'b00, 32'h0});
      rc = req_cycles;
      axi_write(32'h0000_0200, 3'd7, 8'd0, 32'hCAFE_F00D, 4'hF, 1, 4, lat);
      chk("gnt_delay_req_cycles", req_cycles - rc, 6);
      gnt_delay = 0;

      // Byte strobes merge into a fully written word; reads always use all byte enables.
      creq_q.push_back('{1'b1, 32'h0000_0300, 4'hF, 32'hFFFF_FFFF});
      rsp_q.push_back('{1'b1, 3'd0, 2'b00, 32'h0});
      axi_write(32'h0000_0300, 3'd0, 8'd0, 32'hFFFF_FFFF, 4'hF, 1, 0, lat);
      creq_q.push_back('{1'b1, 32'h0000_0300, 4'h6, 32'h1122_3344});
      rsp_q.push_back('{1'b1, 3'd1, 2'b00, 32'h0});
      axi_write(32'h0000_0300, 3'd1, 8'd0, 32'h1122_3344, 4'h6, 1, 0, lat);
      creq_q.push_back('{1'b0, 32'h0000_0300, 4'hF, 32'h0});
      rsp_q.push_back('{1'b0, 3'd2, 2'b00, 32'hFF22_33FF});
      axi_read(32'h0000_0300, 3'd2, 8'd0, 2, lat);

      // Burst rejection on both channels: SLVERR, no core traffic.
      rc = req_cycles;
      rsp_q.push_back('{1'b1, 3'd3, 2'b10, 32'h0});
      axi_write(32'h0000_0400, 3'd3, 8'd3, 32'hA000_0000, 4'hF, 4, 0, lat);
      rsp_q.push_back('{1'b0, 3'd5, 2'b10, 32'h0});
      axi_read(32'h0000_0400, 3'd5, 8'd1, 0, lat);
      chk("burst_no_core_req", req_cycles - rc, 0);

      // Reset while waiting for read completion; the late completion must be ignored.
      rv_delay = 4;
      creq_q.push_back('{1'b0, 32'h1000_0010, 4'hF, 32'h0});
      bif.ar_valid = 1'b1; bif.ar_addr = 32'h1000_0010; bif.ar_id = 3'd1; bif.ar_len = 8'd0;
      n = 0;
      @(negedge clk);
      while (!bif.ar_ready && n < 50) begin n++; @(negedge clk); end
      chk("rst_ar_accept", n < 50, 1'b1);
      @(posedge clk); #1;
      bif.ar_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!(bif.data_req_o && bif.data_gnt_i) && n < 50) begin n++; @(negedge clk); end
      chk("rst_read_granted", n < 50, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rv_seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bif.r_valid) rv_seen = 1'b1;
      end
      chk("rst_no_r_valid", rv_seen, 1'b0);
      chk("rst_outputs_after_late_rvalid", outs(), '0);
      rv_delay = 1;

      // Recovery after reset.
      @(posedge clk); #1;
      creq_q.push_back('{1'b0, 32'h0000_0104, 4'hF, 32'h0});
      rsp_q.push_back('{1'b0, 3'd4, 2'b00, 32'h2222_2222});
      axi_read(32'h0000_0104, 3'd4, 8'd0, 0, lat);

      repeat (3) @(negedge clk);
      chk("rsp_queue_drained", rsp_q.size(), 0);
      chk("core_queue_drained", creq_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
